// File: rtl/uart_pkg.sv
// Shared UART definitions: parity_type encodings (also used by the transmit
// side) and the receive deframer state encoding.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // True when the mode carries a parity bit (11 is treated as none).
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  // Expected parity bit given the XOR of all data bits.
  function automatic logic expected_parity(input logic [1:0] mode, input logic data_xor);
    logic exp_bit;
    case (mode)
      PAR_EVEN: exp_bit = data_xor;
      PAR_ODD:  exp_bit = ~data_xor;
      default:  exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input with a
// configurable reset value (idle level of the line).
module uart_bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: oversampled start detect, LSB-first data shift,
// optional parity check, STOP_BITS stop checks, one-clk result strobe.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 par_err_q, par_err_d;
  logic                 fr_err_q, fr_err_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 fr_now_s;

  uart_bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_in),
    .q_o (rx_s)
  );

  // Frame sequencing: next state, counters, shift register and result strobe.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_mode_d = par_mode_q;
    par_err_d  = par_err_q;
    fr_err_d   = fr_err_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    fr_now_s   = fr_err_q | ~rx_s;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          tick_d     = '0;
          par_mode_d = parity_type;
          par_err_d  = 1'b0;
          fr_err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            bit_d  = '0;
            if (!rx_s) begin
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end else begin
          tick_d = tick_q;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = parity_enabled(par_mode_q) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end else begin
          tick_d = tick_q;
        end
      end

      PARITY: begin
        if (baud_tick) begin
          if (tick_q == TICK_END) begin
            tick_d    = '0;
            bit_d     = '0;
            par_err_d = (rx_s != expected_parity(par_mode_q, ^shreg_q));
            state_d   = STOP;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end else begin
          tick_d = tick_q;
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (tick_q == TICK_END) begin
            tick_d   = '0;
            fr_err_d = fr_now_s;
            if (bit_q == STOP_LAST) begin
              bit_d      = '0;
              valid_d    = 1'b1;
              data_out_d = shreg_q;
              perr_d     = par_err_q;
              ferr_d     = fr_now_s;
              state_d    = fr_now_s ? WAIT_HIGH : IDLE;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end else begin
          tick_d = tick_q;
        end
      end

      WAIT_HIGH: begin
        // Hold off new frames while the line is in a break condition.
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_mode_q <= PAR_NONE;
      par_err_q  <= 1'b0;
      fr_err_q   <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_mode_q <= par_mode_d;
      par_err_q  <= par_err_d;
      fr_err_q   <= fr_err_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1/8-parity instance and a
// 7-bit, 2-stop-bit instance, baud_tick held high (16 clks per bit).
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx1, rx2;
  logic [1:0] pt1, pt2;

  logic [7:0] data1;
  logic       dv1, perr1, ferr1, busy1;
  logic [6:0] data2;
  logic       dv2, perr2, ferr2, busy2;

  int tests_run    = 0;
  int tests_failed = 0;
  int vcnt1 = 0;
  int vcnt2 = 0;
  int c0;
  bit busy_seen1 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) u_dut1 (
    .clk (clk), .rst (rst), .baud_tick (baud_tick), .rx_in (rx1),
    .parity_type (pt1), .data_out (data1), .data_valid (dv1),
    .parity_error (perr1), .framing_error (ferr1), .busy (busy1)
  );

  uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2)) u_dut2 (
    .clk (clk), .rst (rst), .baud_tick (baud_tick), .rx_in (rx2),
    .parity_type (pt2), .data_out (data2), .data_valid (dv2),
    .parity_error (perr2), .framing_error (ferr2), .busy (busy2)
  );

  // Count result strobes and note any busy activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (dv1) vcnt1 = vcnt1 + 1;
    if (dv2) vcnt2 = vcnt2 + 1;
    if (busy1) busy_seen1 = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send n line bits, LSB of 'bits' first, 16 clks each, on instance inst.
  task automatic send_bits(input int inst, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (inst == 1) rx1 = bits[i];
      else           rx2 = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; baud_tick = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    pt1 = 2'b10; pt2 = 2'b10;
    repeat (3) @(negedge clk);
    check_eq("rst_data",  {24'd0, data1}, 32'd0);
    check_eq("rst_valid", {31'd0, dv1},   32'd0);
    check_eq("rst_perr",  {31'd0, perr1}, 32'd0);
    check_eq("rst_ferr",  {31'd0, ferr1}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy1}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Even parity, 0xA5, parity bit 0
    c0 = vcnt1;
    send_bits(1, {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    repeat (4) @(negedge clk);
    check_eq("even_data",  {24'd0, data1}, 32'hA5);
    check_eq("even_count", vcnt1 - c0,     32'd1);
    check_eq("even_perr",  {31'd0, perr1}, 32'd0);
    check_eq("even_ferr",  {31'd0, ferr1}, 32'd0);
    check_eq("even_busy",  {31'd0, busy1}, 32'd0);

    // Odd parity: 0xA5 with wrong parity bit, then 0x3C correct
    pt1 = 2'b01;
    send_bits(1, {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    repeat (4) @(negedge clk);
    check_eq("odd_bad_data", {24'd0, data1}, 32'hA5);
    check_eq("odd_bad_perr", {31'd0, perr1}, 32'd1);
    send_bits(1, {5'd0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    repeat (4) @(negedge clk);
    check_eq("odd_ok_data", {24'd0, data1}, 32'h3C);
    check_eq("odd_ok_perr", {31'd0, perr1}, 32'd0);

    // Framing error followed by a long break
    pt1 = 2'b00;
    c0 = vcnt1;
    send_bits(1, {6'd0, 1'b0, 8'h00, 1'b0}, 10);
    repeat (40 * 16) @(negedge clk);
    check_eq("brk_count", vcnt1 - c0,     32'd1);
    check_eq("brk_ferr",  {31'd0, ferr1}, 32'd1);
    check_eq("brk_data",  {24'd0, data1}, 32'h00);
    check_eq("brk_busy",  {31'd0, busy1}, 32'd1);
    rx1 = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("brk_release_busy",  {31'd0, busy1}, 32'd0);
    check_eq("brk_release_count", vcnt1 - c0,     32'd1);
    send_bits(1, {6'd0, 1'b1, 8'h81, 1'b0}, 10);
    repeat (4) @(negedge clk);
    check_eq("post_brk_data",  {24'd0, data1}, 32'h81);
    check_eq("post_brk_ferr",  {31'd0, ferr1}, 32'd0);
    check_eq("post_brk_count", vcnt1 - c0,     32'd2);

    // Glitch rejection: 4-tick low pulse
    c0 = vcnt1;
    busy_seen1 = 1'b0;
    rx1 = 1'b0;
    repeat (4) @(negedge clk);
    rx1 = 1'b1;
    repeat (24) @(negedge clk);
    check_eq("glitch_busy_seen", {31'd0, busy_seen1}, 32'd1);
    check_eq("glitch_busy",      {31'd0, busy1},      32'd0);
    check_eq("glitch_count",     vcnt1 - c0,          32'd0);
    check_eq("glitch_data",      {24'd0, data1},      32'h81);
    check_eq("glitch_ferr",      {31'd0, ferr1},      32'd0);

    // Reset during the 4th data bit of 0x5A
    c0 = vcnt1;
    send_bits(1, {12'd0, 3'b010, 1'b0}, 4);
    rx1 = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_data",  {24'd0, data1}, 32'd0);
    check_eq("midrst_valid", {31'd0, dv1},   32'd0);
    check_eq("midrst_perr",  {31'd0, perr1}, 32'd0);
    check_eq("midrst_ferr",  {31'd0, ferr1}, 32'd0);
    check_eq("midrst_busy",  {31'd0, busy1}, 32'd0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midrst_count", vcnt1 - c0, 32'd0);
    send_bits(1, {6'd0, 1'b1, 8'hC3, 1'b0}, 10);
    repeat (4) @(negedge clk);
    check_eq("after_rst_data",  {24'd0, data1}, 32'hC3);
    check_eq("after_rst_perr",  {31'd0, perr1}, 32'd0);
    check_eq("after_rst_ferr",  {31'd0, ferr1}, 32'd0);
    check_eq("after_rst_count", vcnt1 - c0,     32'd1);

    // 7 data bits, even parity, 2 stop bits: second stop low, then both high
    pt2 = 2'b10;
    c0 = vcnt2;
    send_bits(2, {5'd0, 1'b0, 1'b1, 1'b0, 7'h55, 1'b0}, 11);
    rx2 = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("p7_bad_data",  {25'd0, data2}, 32'h55);
    check_eq("p7_bad_ferr",  {31'd0, ferr2}, 32'd1);
    check_eq("p7_bad_perr",  {31'd0, perr2}, 32'd0);
    check_eq("p7_bad_count", vcnt2 - c0,     32'd1);
    send_bits(2, {5'd0, 1'b1, 1'b1, 1'b0, 7'h55, 1'b0}, 11);
    repeat (4) @(negedge clk);
    check_eq("p7_ok_data",  {25'd0, data2}, 32'h55);
    check_eq("p7_ok_ferr",  {31'd0, ferr2}, 32'd0);
    check_eq("p7_ok_perr",  {31'd0, perr2}, 32'd0);
    check_eq("p7_ok_count", vcnt2 - c0,     32'd2);
    check_eq("p7_ok_busy",  {31'd0, busy2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receive deframer. Oversamples the serial line, detects the start bit, shifts in DATA_BITS data bits LSB-first, and checks an optional parity bit and STOP_BITS stop bits. Presents each received word with one-cycle valid and error flags. Sits between the pad-side rx line and the receive FIFO, and uses the same 2-bit parity_type encoding as the transmit-side parity generator.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4)
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
baud_tick  in  1  oversample enable, one clk wide; all bit timing counts only these pulses
rx_in  in  1  asynchronous serial line, idle high
parity_type  in  2  00 none, 01 odd, 10 even, 11 none
data_out  out  DATA_BITS  last received word
data_valid  out  1  one-clk pulse: data_out and error flags updated
parity_error  out  1  parity mismatch on last word
framing_error  out  1  a checked stop bit sampled low on last word
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; data_out=0; data_valid=0; parity_error=0; framing_error=0; busy=0; sync flops=1; tick/bit counters=0.
- rx_in passes through a 2-FF synchroniser (reset value 1) to give rx_s. All decisions use rx_s.
- IDLE: rx_s==0 -> START; tick_cnt=0; latch parity_type into par_mode. A parity_type change mid-frame has no effect.
- START: count baud_ticks. At tick_cnt==OVERSAMPLE/2-1, sample: 0 -> DATA, tick_cnt=0, bit_cnt=0; 1 -> IDLE (glitch rejected, no data_valid).
- DATA: sample on every OVERSAMPLE-th tick (bit centre). Shift right into shreg so the first bit lands at the LSB. After bit_cnt==DATA_BITS-1: par_mode in {01,10} -> PARITY, else -> STOP.
- PARITY: sample at bit centre. Expected bit: even = ^shreg; odd = ~^shreg. par_err = sampled != expected. Then -> STOP.
- STOP: sample at each of STOP_BITS bit centres; fr_err |= (sample==0).
  - On the last stop sample: the next clk drives data_out=shreg, parity_error=par_err (0 when no parity), framing_error=fr_err, data_valid=1 for exactly one clk.
  - Next state: fr_err=0 -> IDLE; fr_err=1 -> WAIT_HIGH.
- WAIT_HIGH: stays until rx_s==1, then -> IDLE. This stops a break condition from retriggering frames.
- Latency: data_valid is asserted 1 clk after the baud_tick that samples the last stop bit.
- Error flags and data_out hold until the next data_valid.
- A frame abandoned by glitch rejection or reset never pulses data_valid.
- baud_tick low: all counters hold. rx_s is ignored except for the IDLE start detect and the WAIT_HIGH release.
- Reset asserted mid-frame: immediate return to reset values. The first full frame after release is received correctly.
- DATA_BITS=9 with parity enabled gives a 12-bit frame (start, 9 data, parity, stop). The counters must be sized for it.

Decomposition:
- Package uart_pkg: parity_type encodings (PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10) and the rx state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH). The tx side uses the same encodings.
- One sub-module, uart_bit_sync: 2-FF synchroniser with parametrised reset value (1 here).
- Counter widths come from $clog2(OVERSAMPLE) and $clog2(DATA_BITS+1).

Test Plan:
- Even parity, byte 0xA5: DATA_BITS=8, OVERSAMPLE=16, baud_tick every clk. Send 0xA5 with parity bit 0 and stop bit 1 -> data_out=0xA5, one data_valid pulse, parity_error=0, framing_error=0, busy back to 0.
- Odd parity error: parity_type=01, send 0xA5 with parity bit 0 (expected 1) -> data_out=0xA5, parity_error=1. A following correct frame 0x3C with parity bit 1 -> parity_error=0.
- Framing error and break: send 0x00 with stop bit 0, then hold rx low for 40 bit times -> one data_valid with framing_error=1, state WAIT_HIGH, no further data_valid until rx goes high and a new start bit arrives.
- Glitch rejection: rx low for 4 ticks, then high -> busy pulses and returns to 0, no data_valid, flags unchanged.
- Reset mid-frame: assert rst during the 4th data bit of 0x5A -> all outputs 0 immediately. After release, 0xC3 with no parity -> data_out=0xC3, errors 0.
- Parametric case: DATA_BITS=7, STOP_BITS=2, parity_type=10. Send 0x55 with parity 0; the second stop bit is low -> framing_error=1. Repeat with both stops high -> framing_error=0.
